jtag_scan_master: RTL

Host-side JTAG scan engine: drives TCK/TMS/TDI and samples TDO to perform IR scans, DR scans, TAP resets and idle clocking against the Nios II debug TAP and virtual-JTAG targets. It sits in FPGA fabric as a command/response slave to a local controller (an on-chip test sequencer or bridge) and is the initiator counterpart of the debug slave's shift logic. Every command runs from Run-Test/Idle and returns to Run-Test/Idle.

---
 rtl/jtag_scan_master.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_scan_master.sv
// Host-side JTAG scan engine: runs TAP reset, IR/DR scans and idle clocking from
// Run-Test/Idle and returns captured TDO through a valid/ready response.
module jtag_scan_master #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned IR_MAX  = 10,
    parameter int unsigned DR_MAX  = 38
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [5:0]        cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);

    localparam int unsigned LEN_W = 6;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(2 * CLK_DIV - 1);

    localparam logic [1:0] CMD_TAP_RESET = 2'd0;
    localparam logic [1:0] CMD_IR_SCAN   = 2'd1;
    localparam logic [1:0] CMD_DR_SCAN   = 2'd2;
    localparam logic [1:0] CMD_IDLE      = 2'd3;

    typedef enum logic [1:0] {POR_RESET, IDLE, RUN, RESP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         kind_q, kind_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   n_q, n_d;
    logic [LEN_W-1:0]   tck_cnt_q, tck_cnt_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               shift_q, shift_d;
    logic [DR_MAX-1:0]  data_q, data_d;
    logic [DR_MAX-1:0]  rsp_q, rsp_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [LEN_W-1:0]   eff_len;
    logic [LEN_W-1:0]   eff_n;

    // TMS value for TCK number j of a command of the given kind and shift length
    function automatic logic tms_at(input logic [1:0] kind, input logic [LEN_W-1:0] len,
                                    input logic [LEN_W-1:0] j);
        logic t;
        t = 1'b0;
        case (kind)
            CMD_TAP_RESET: t = (j < 6'd5);
            CMD_IR_SCAN: begin
                if (j < 6'd2)             t = 1'b1;
                else if (j < 6'd4)        t = 1'b0;
                else if (j < len + 6'd4)  t = (j == len + 6'd3);
                else                      t = (j == len + 6'd4);
            end
            CMD_DR_SCAN: begin
                if (j == 6'd0)            t = 1'b1;
                else if (j < 6'd3)        t = 1'b0;
                else if (j < len + 6'd3)  t = (j == len + 6'd2);
                else                      t = (j == len + 6'd3);
            end
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic shift_at(input logic [1:0] kind, input logic [LEN_W-1:0] len,
                                      input logic [LEN_W-1:0] j);
        logic s;
        s = 1'b0;
        case (kind)
            CMD_IR_SCAN: s = (j >= 6'd4) && (j < len + 6'd4);
            CMD_DR_SCAN: s = (j >= 6'd3) && (j < len + 6'd3);
            default:     s = 1'b0;
        endcase
        return s;
    endfunction

    // Effective shift length (0 runs as 1, clamped to max) and total TCK count
    always_comb begin
        eff_len = cmd_len;
        eff_n   = cmd_len;
        case (cmd_type)
            CMD_TAP_RESET: begin
                eff_len = '0;
                eff_n   = 6'd6;
            end
            CMD_IR_SCAN: begin
                if (cmd_len == '0)                    eff_len = 6'd1;
                else if (cmd_len > LEN_W'(IR_MAX))    eff_len = LEN_W'(IR_MAX);
                eff_n = eff_len + 6'd6;
            end
            CMD_DR_SCAN: begin
                if (cmd_len == '0)                    eff_len = 6'd1;
                else if (cmd_len > LEN_W'(DR_MAX))    eff_len = LEN_W'(DR_MAX);
                eff_n = eff_len + 6'd5;
            end
            CMD_IDLE: eff_len = cmd_len;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        len_d       = len_q;
        n_d         = n_q;
        tck_cnt_d   = tck_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        div_d       = div_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rsp_d       = rsp_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            POR_RESET, RUN: begin
                if (state_q == RUN && tck_cnt_q == n_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                    if (div_q == HALF_LAST) tck_d = 1'b1;
                    // End of high phase: tck falls, TDO sampled, next TCK's TMS/TDI launched
                    if (div_q == FULL_LAST) begin
                        tck_d = 1'b0;
                        div_d = '0;
                        if (shift_q) begin
                            rsp_d[bit_cnt_q] = tdo;
                            bit_cnt_d        = bit_cnt_q + 6'd1;
                        end
                        tck_cnt_d = tck_cnt_q + 6'd1;
                        if (tck_cnt_d < n_q) begin
                            tms_d   = tms_at(kind_q, len_q, tck_cnt_d);
                            shift_d = shift_at(kind_q, len_q, tck_cnt_d);
                            tdi_d   = shift_d ? data_q[0] : 1'b0;
                            if (shift_d) data_d = data_q >> 1;
                        end else begin
                            tms_d   = 1'b0;
                            tdi_d   = 1'b0;
                            shift_d = 1'b0;
                            if (state_q == POR_RESET) begin
                                state_d     = IDLE;
                                cmd_ready_d = 1'b1;
                            end
                        end
                    end
                end
            end
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = RUN;
                    cmd_ready_d = 1'b0;
                    kind_d      = cmd_type;
                    len_d       = eff_len;
                    n_d         = eff_n;
                    tck_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    div_d       = '0;
                    tck_d       = 1'b0;
                    tdi_d       = 1'b0;
                    shift_d     = 1'b0;
                    data_d      = cmd_data;
                    rsp_d       = '0;
                    tms_d       = (eff_n != '0) ? tms_at(cmd_type, eff_len, 6'd0) : 1'b0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = POR_RESET;
        endcase
    end

    // Reset parks the engine at the start of the POR TAP reset sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= POR_RESET;
            kind_q      <= CMD_TAP_RESET;
            len_q       <= '0;
            n_q         <= 6'd6;
            tck_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            shift_q     <= 1'b0;
            data_q      <= '0;
            rsp_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            len_q       <= len_d;
            n_q         <= n_d;
            tck_cnt_q   <= tck_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rsp_q       <= rsp_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

endmodule
